// File: rtl/fa_tag_alloc_ctrl.sv
// Fully-associative tag lookup with miss allocation and refill handshake.
// Every hit or completed fill emits one access pulse to the downstream LRU block.
module fa_tag_alloc_ctrl #(
  parameter int NO_ENTRY  = 8,
  parameter int IDX_WIDTH = $clog2(NO_ENTRY),
  parameter int TAG_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [TAG_WIDTH-1:0] req_tag,
  output logic                 rsp_valid,
  output logic                 rsp_hit,
  output logic [IDX_WIDTH-1:0] rsp_idx,
  output logic                 fill_req_valid,
  input  logic                 fill_req_ready,
  output logic [TAG_WIDTH-1:0] fill_req_tag,
  output logic [IDX_WIDTH-1:0] fill_req_idx,
  input  logic                 fill_done,
  output logic                 acc_en,
  output logic [IDX_WIDTH-1:0] acc_idx,
  input  logic [IDX_WIDTH-1:0] lru_idx
);

  typedef enum logic [2:0] {
    IDLE,
    VICTIM,
    FILL_REQ,
    FILL_WAIT,
    FILL_RESP
  } state_t;

  state_t state, state_nxt;

  logic [TAG_WIDTH-1:0] tag_mem [NO_ENTRY];
  logic [NO_ENTRY-1:0]  valid;
  logic [TAG_WIDTH-1:0] miss_tag;

  logic                 accept_p0;
  logic [NO_ENTRY-1:0]  hit_vec_p0;
  logic                 hit_p0;
  logic [IDX_WIDTH-1:0] hit_idx_p0;
  logic [IDX_WIDTH-1:0] victim_idx;
  logic                 fill_commit;

  // Lowest set bit of a vector; used both as the one-hot hit encoder and
  // as the invalid-first victim picker.
  function automatic logic [IDX_WIDTH-1:0] first_set(input logic [NO_ENTRY-1:0] vec);
    logic [IDX_WIDTH-1:0] idx;
    idx = '0;
    for (int i = NO_ENTRY - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_WIDTH'(i);
    end
    return idx;
  endfunction

  // Lookup stage: tag compare against all valid entries in the accept cycle
  assign accept_p0   = (state == IDLE) && req_ready && req_valid && !flush;
  assign fill_commit = (state == FILL_WAIT) && fill_done;

  always_comb begin
    hit_vec_p0 = '0;
    for (int i = 0; i < NO_ENTRY; i++) begin
      hit_vec_p0[i] = valid[i] && (tag_mem[i] == req_tag);
    end
  end

  assign hit_p0     = |hit_vec_p0;
  assign hit_idx_p0 = first_set(hit_vec_p0);
  assign victim_idx = (&valid) ? lru_idx : first_set(~valid);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept_p0 && !hit_p0) state_nxt = VICTIM;
      VICTIM:    state_nxt = FILL_REQ;
      FILL_REQ:  if (fill_req_ready) state_nxt = FILL_WAIT;
      FILL_WAIT: if (fill_done) state_nxt = FILL_RESP;
      FILL_RESP: state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if ((state == IDLE) && flush) begin
      valid <= '0;
    end else if (fill_commit) begin
      valid[fill_req_idx] <= 1'b1;
    end
  end

  // Tag storage and the pending miss tag carry no reset; valid bits gate them.
  always_ff @(posedge clk) begin
    if (accept_p0) miss_tag <= req_tag;
    if (fill_commit) tag_mem[fill_req_idx] <= miss_tag;
  end

  // Response stage: all outputs registered, pulses default low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready      <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_hit        <= 1'b0;
      rsp_idx        <= '0;
      fill_req_valid <= 1'b0;
      fill_req_tag   <= '0;
      fill_req_idx   <= '0;
      acc_en         <= 1'b0;
      acc_idx        <= '0;
    end else begin
      req_ready <= (state_nxt == IDLE);
      rsp_valid <= 1'b0;
      acc_en    <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_p0 && hit_p0) begin
            rsp_valid <= 1'b1;
            rsp_hit   <= 1'b1;
            rsp_idx   <= hit_idx_p0;
            acc_en    <= 1'b1;
            acc_idx   <= hit_idx_p0;
          end
        end
        VICTIM: begin
          fill_req_valid <= 1'b1;
          fill_req_tag   <= miss_tag;
          fill_req_idx   <= victim_idx;
        end
        FILL_REQ: begin
          if (fill_req_ready) fill_req_valid <= 1'b0;
        end
        FILL_WAIT: begin
          if (fill_done) begin
            rsp_valid <= 1'b1;
            rsp_hit   <= 1'b0;
            rsp_idx   <= fill_req_idx;
            acc_en    <= 1'b1;
            acc_idx   <= fill_req_idx;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fa_tag_alloc_ctrl.sv
// Directed bench for fa_tag_alloc_ctrl with a behavioural linked-list LRU attached.
module tb_fa_tag_alloc_ctrl;

  localparam int NO_ENTRY  = 8;
  localparam int IDX_WIDTH = 3;
  localparam int TAG_WIDTH = 20;

  logic                 clk;
  logic                 rst_n;
  logic                 flush;
  logic                 req_valid;
  logic                 req_ready;
  logic [TAG_WIDTH-1:0] req_tag;
  logic                 rsp_valid;
  logic                 rsp_hit;
  logic [IDX_WIDTH-1:0] rsp_idx;
  logic                 fill_req_valid;
  logic                 fill_req_ready;
  logic [TAG_WIDTH-1:0] fill_req_tag;
  logic [IDX_WIDTH-1:0] fill_req_idx;
  logic                 fill_done;
  logic                 acc_en;
  logic [IDX_WIDTH-1:0] acc_idx;
  logic [IDX_WIDTH-1:0] lru_idx;

  int n_checks = 0;
  int n_errors = 0;

  fa_tag_alloc_ctrl #(
    .NO_ENTRY (NO_ENTRY),
    .IDX_WIDTH(IDX_WIDTH),
    .TAG_WIDTH(TAG_WIDTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_tag       (req_tag),
    .rsp_valid     (rsp_valid),
    .rsp_hit       (rsp_hit),
    .rsp_idx       (rsp_idx),
    .fill_req_valid(fill_req_valid),
    .fill_req_ready(fill_req_ready),
    .fill_req_tag  (fill_req_tag),
    .fill_req_idx  (fill_req_idx),
    .fill_done     (fill_done),
    .acc_en        (acc_en),
    .acc_idx       (acc_idx),
    .lru_idx       (lru_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // LRU block: order[0] is least recent, each access moves the index to the tail
  logic [IDX_WIDTH-1:0] lru_order [NO_ENTRY];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NO_ENTRY; i++) lru_order[i] <= IDX_WIDTH'(i);
    end else if (acc_en) begin
      logic [IDX_WIDTH-1:0] tmp [NO_ENTRY];
      int k;
      k = 0;
      for (int i = 0; i < NO_ENTRY; i++) begin
        if (lru_order[i] != acc_idx && k < NO_ENTRY - 1) begin
          tmp[k] = lru_order[i];
          k++;
        end
      end
      tmp[NO_ENTRY-1] = acc_idx;
      lru_order <= tmp;
    end
  end

  assign lru_idx = lru_order[0];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Called in the cycle after a miss was accepted; fill_req_ready assumed high.
  task automatic finish_miss(input logic [TAG_WIDTH-1:0] tag, input int exp);
    chk("miss_ready_low", 32'(req_ready), 0);
    chk("miss_no_rsp", 32'(rsp_valid), 0);
    chk("miss_no_fill_yet", 32'(fill_req_valid), 0);
    tick();
    chk("fill_req_valid", 32'(fill_req_valid), 1);
    chk("fill_req_idx", 32'(fill_req_idx), 32'(exp));
    chk("fill_req_tag", 32'(fill_req_tag), 32'(tag));
    tick();
    chk("fill_req_dropped", 32'(fill_req_valid), 0);
    chk("miss_no_rsp_wait", 32'(rsp_valid), 0);
    fill_done = 1'b1;
    tick();
    fill_done = 1'b0;
    chk("miss_rsp_valid", 32'(rsp_valid), 1);
    chk("miss_rsp_hit", 32'(rsp_hit), 0);
    chk("miss_rsp_idx", 32'(rsp_idx), 32'(exp));
    chk("miss_acc_en", 32'(acc_en), 1);
    chk("miss_acc_idx", 32'(acc_idx), 32'(exp));
    tick();
    chk("miss_rsp_pulse", 32'(rsp_valid), 0);
    chk("miss_acc_pulse", 32'(acc_en), 0);
    chk("miss_ready_back", 32'(req_ready), 1);
  endtask

  task automatic lookup_miss(input logic [TAG_WIDTH-1:0] tag, input int exp);
    chk("req_ready", 32'(req_ready), 1);
    req_valid = 1'b1;
    req_tag   = tag;
    tick();
    req_valid = 1'b0;
    finish_miss(tag, exp);
  endtask

  task automatic lookup_hit(input logic [TAG_WIDTH-1:0] tag, input int exp);
    chk("req_ready", 32'(req_ready), 1);
    req_valid = 1'b1;
    req_tag   = tag;
    tick();
    req_valid = 1'b0;
    chk("hit_rsp_valid", 32'(rsp_valid), 1);
    chk("hit_rsp_hit", 32'(rsp_hit), 1);
    chk("hit_rsp_idx", 32'(rsp_idx), 32'(exp));
    chk("hit_acc_en", 32'(acc_en), 1);
    chk("hit_acc_idx", 32'(acc_idx), 32'(exp));
    chk("hit_ready", 32'(req_ready), 1);
    tick();
    chk("hit_rsp_pulse", 32'(rsp_valid), 0);
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_req_ready"}, 32'(req_ready), 0);
    chk({pfx, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({pfx, "_rsp_hit"}, 32'(rsp_hit), 0);
    chk({pfx, "_rsp_idx"}, 32'(rsp_idx), 0);
    chk({pfx, "_fill_valid"}, 32'(fill_req_valid), 0);
    chk({pfx, "_fill_tag"}, 32'(fill_req_tag), 0);
    chk({pfx, "_fill_idx"}, 32'(fill_req_idx), 0);
    chk({pfx, "_acc_en"}, 32'(acc_en), 0);
    chk({pfx, "_acc_idx"}, 32'(acc_idx), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    flush          = 1'b0;
    req_valid      = 1'b0;
    req_tag        = '0;
    fill_req_ready = 1'b1;
    fill_done      = 1'b0;

    // Reset state and first ready cycle
    tick();
    tick();
    chk_all_zero("rst");
    rst_n = 1'b1;
    chk("rst_ready_still_low", 32'(req_ready), 0);
    tick();
    chk("rst_ready_rise", 32'(req_ready), 1);

    // Test 1: fill all entries invalid-first
    for (int i = 0; i < NO_ENTRY; i++) begin
      lookup_miss(TAG_WIDTH'(32'h100 + i), i);
    end

    // Test 2: back-to-back hits
    req_valid = 1'b1;
    req_tag   = 20'h103;
    tick();
    req_tag = 20'h105;
    chk("b2b_ready", 32'(req_ready), 1);
    chk("b2b0_valid", 32'(rsp_valid), 1);
    chk("b2b0_hit", 32'(rsp_hit), 1);
    chk("b2b0_idx", 32'(rsp_idx), 3);
    chk("b2b0_acc", 32'(acc_en), 1);
    chk("b2b0_acc_idx", 32'(acc_idx), 3);
    tick();
    req_valid = 1'b0;
    chk("b2b1_valid", 32'(rsp_valid), 1);
    chk("b2b1_hit", 32'(rsp_hit), 1);
    chk("b2b1_idx", 32'(rsp_idx), 5);
    chk("b2b1_acc", 32'(acc_en), 1);
    chk("b2b1_acc_idx", 32'(acc_idx), 5);
    tick();
    chk("b2b_acc_end", 32'(acc_en), 0);

    // Test 3: all valid, victims come from the LRU (0, then 1)
    lookup_miss(20'h200, 0);
    lookup_miss(20'h100, 1);

    // Test 4: make entry 7 the LRU, then hit it and miss right after
    lookup_hit(20'h102, 2);
    lookup_hit(20'h104, 4);
    lookup_hit(20'h106, 6);
    req_valid = 1'b1;
    req_tag   = 20'h107;
    tick();
    chk("t4_hit_idx", 32'(rsp_idx), 7);
    chk("t4_hit_acc", 32'(acc_en), 1);
    chk("t4_ready", 32'(req_ready), 1);
    req_tag = 20'h300;
    tick();
    req_valid = 1'b0;
    finish_miss(20'h300, 3);

    // Test 5: stalled refill request and an early fill_done
    fill_req_ready = 1'b0;
    chk("t5_ready", 32'(req_ready), 1);
    req_valid = 1'b1;
    req_tag   = 20'h400;
    tick();
    req_valid = 1'b0;
    chk("t5_ready_low", 32'(req_ready), 0);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t5_fill_valid", 32'(fill_req_valid), 1);
      chk("t5_fill_tag", 32'(fill_req_tag), 32'h400);
      chk("t5_fill_idx", 32'(fill_req_idx), 5);
      chk("t5_no_rsp", 32'(rsp_valid), 0);
      fill_done = (c == 1);
      if (c == 4) fill_req_ready = 1'b1;
    end
    tick();
    chk("t5_fill_dropped", 32'(fill_req_valid), 0);
    chk("t5_early_done_ignored", 32'(rsp_valid), 0);
    tick();
    chk("t5_still_waiting", 32'(rsp_valid), 0);
    fill_done = 1'b1;
    tick();
    fill_done = 1'b0;
    chk("t5_rsp_valid", 32'(rsp_valid), 1);
    chk("t5_rsp_hit", 32'(rsp_hit), 0);
    chk("t5_rsp_idx", 32'(rsp_idx), 5);
    chk("t5_acc_idx", 32'(acc_idx), 5);
    tick();
    chk("t5_rsp_pulse", 32'(rsp_valid), 0);
    lookup_hit(20'h400, 5);

    // Test 6: flush, then reset during FILL_WAIT
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_no_rsp", 32'(rsp_valid), 0);
    lookup_miss(20'h103, 0);
    req_valid = 1'b1;
    req_tag   = 20'h500;
    tick();
    req_valid = 1'b0;
    tick();
    chk("t6_fill_idx", 32'(fill_req_idx), 1);
    chk("t6_fill_tag", 32'(fill_req_tag), 32'h500);
    tick();
    chk("t6_in_wait", 32'(fill_req_valid), 0);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    tick();
    rst_n     = 1'b1;
    fill_done = 1'b1;
    chk("t6_ready_low", 32'(req_ready), 0);
    tick();
    fill_done = 1'b0;
    chk("t6_ready_rise", 32'(req_ready), 1);
    chk("t6_stale_done_rsp", 32'(rsp_valid), 0);
    chk("t6_stale_done_acc", 32'(acc_en), 0);
    lookup_miss(20'h103, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fa_tag_alloc_ctrl.md
Name: fa_tag_alloc_ctrl

Overview:
Fully-associative tag lookup and allocation controller that sits directly upstream of the linked-list LRU block and drives its acc_en/acc_idx inputs. It accepts lookup requests and compares the tag against all valid entries. On a miss it selects a victim (the first invalid entry, else lru_idx), runs a refill handshake, installs the tag, and reports the entry index. Every hit or fill produces exactly one LRU access pulse.

Parameters:
NO_ENTRY, 8, number of fully-associative entries; power of two, at least 2
IDX_WIDTH, $clog2(NO_ENTRY), entry index width
TAG_WIDTH, 20, tag width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  invalidate all entries; honoured only in IDLE
req_valid  in  1  lookup request valid
req_ready  out  1  lookup request accepted when req_valid & req_ready
req_tag  in  TAG_WIDTH  lookup tag
rsp_valid  out  1  one-cycle response pulse; no back-pressure
rsp_hit  out  1  1 = hit, 0 = miss serviced by fill
rsp_idx  out  IDX_WIDTH  entry holding the tag
fill_req_valid  out  1  refill request valid
fill_req_ready  in  1  refill request accepted
fill_req_tag  out  TAG_WIDTH  tag being refilled
fill_req_idx  out  IDX_WIDTH  victim entry being refilled
fill_done  in  1  one-cycle pulse: refill data written
acc_en  out  1  LRU access pulse
acc_idx  out  IDX_WIDTH  LRU access index
lru_idx  in  IDX_WIDTH  current LRU entry from the LRU block

Behaviour:
- Storage: tag[NO_ENTRY], valid[NO_ENTRY]. Reset clears all valid bits.
- All outputs are registered. Reset values: req_ready=0, rsp_valid=0, rsp_hit=0, rsp_idx=0, fill_req_valid=0, fill_req_tag=0, fill_req_idx=0, acc_en=0, acc_idx=0. req_ready rises 1 cycle after reset release.
- FSM states: IDLE, VICTIM, FILL_REQ, FILL_WAIT, FILL_RESP. Reset state is IDLE.
- IDLE: req_ready=1 unless flush=1.
  - flush=1: clear all valid bits; no request accepted that cycle; stay in IDLE.
  - Accepted request: compare req_tag against valid entries in that cycle.
  - Hit: next cycle rsp_valid=1, rsp_hit=1, rsp_idx=acc_idx=hit index, acc_en=1. Stay in IDLE, so back-to-back hits run at 1 per cycle.
  - Miss: latch the tag; req_ready=0 next cycle; go to VICTIM.
- VICTIM (1 cycle): victim = lowest-index invalid entry, else lru_idx sampled in this cycle. This cycle is after any acc_en from a preceding hit has updated the LRU, so lru_idx is current. Go to FILL_REQ.
- FILL_REQ: fill_req_valid=1; fill_req_tag and fill_req_idx are held stable until fill_req_ready=1, then go to FILL_WAIT. fill_done is ignored in this state.
- FILL_WAIT: fill_req_valid=0. On fill_done: tag[victim]<=latched tag, valid[victim]<=1, go to FILL_RESP.
- FILL_RESP (1 cycle): rsp_valid=1, rsp_hit=0, rsp_idx=acc_idx=victim, acc_en=1. Go to IDLE; req_ready=1 in the following cycle.
- Latency:
  - Hit: response 1 cycle after acceptance.
  - Miss: response 4 cycles after acceptance when fill_req_ready is already high and fill_done arrives in the first FILL_WAIT cycle.
- Ordering and pulse rules:
  - At most one request is outstanding during a miss; no hit-under-miss.
  - acc_en pulses exactly once per response, in the same cycle as rsp_valid.
- Invariant: a tag is never present in two valid entries, because fills only occur on a miss.
- flush outside IDLE is ignored; the requester must hold it until req_ready is observed.
- rst_n mid-fill: abort immediately. Go to IDLE, clear all valid bits, deassert all outputs. An in-flight fill_done after reset is ignored.

Test Plan:
1. Reset, then 8 misses with tags 0x100..0x107, each fill acked immediately -> victims 0..7 in order (invalid-first); rsp_hit=0; acc_idx=0..7; latency 4 cycles each.
2. After test 1, back-to-back hits on 0x103, 0x105 -> rsp_hit=1, rsp_idx=3 then 5 on consecutive cycles; acc_en high for 2 cycles.
3. After test 2, miss on 0x200 -> victim = lru_idx from the connected LRU = 0; fill_req_idx=0; later lookup of 0x100 misses.
4. Hit on 0x107 immediately followed by a miss on 0x300 -> VICTIM samples the updated LRU, so the victim is not 7.
5. fill_req_ready held low 5 cycles -> fill_req_tag/idx stable throughout; a fill_done pulsed in FILL_REQ is ignored; the response comes only after a fill_done in FILL_WAIT.
6. flush in IDLE, then lookup 0x103 -> miss, victim 0. rst_n asserted in FILL_WAIT -> all outputs 0, subsequent lookup misses.
